// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single memory port (port A) between an instruction-fetch requester
// and a load/store requester. Each transaction takes three cycles:
//   IDLE   : arbitrate and latch the winner's address, write data and we
//   ACCESS : drive the memory port from the latched values
//   RESP   : pulse the winner's valid; return mem_rdata for reads
//
// Arbitration: fixed priority (load/store beats fetch) by default. When the
// macro MEM_ARB_ROUND_ROBIN_EN is defined, a 1-bit last-winner register makes
// simultaneous requests alternate, with the first tie after reset going to
// load/store.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   if_req, if_addr       fetch request (held until if_valid) and address
//   ls_req, ls_we,        load/store request (held until ls_valid), write
//   ls_addr, ls_wdata     enable, address and store data
//   if_gnt, ls_gnt        requester owns the port (ACCESS and RESP)
//   if_valid, ls_valid    one-cycle completion pulse in RESP
//   rdata                 mem_rdata during RESP of a read, else 0
//   mem_en, mem_we,       memory port A controls, non-zero only in ACCESS
//   mem_addr, mem_wdata
//   mem_rdata             memory read data, valid one cycle after mem_en
module mem_port_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [15:0] ls_addr,
    input  logic [15:0] ls_wdata,
    output logic        if_gnt,
    output logic        ls_gnt,
    output logic        if_valid,
    output logic        ls_valid,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        any_req;
    logic        pick_ls;
    logic        start;
    logic        owner_ls;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_we;

    assign any_req = if_req | ls_req;
    assign start   = (state == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 when load/store won the most recent arbitration; reset points at fetch
    // so the first tie goes to load/store.
    logic last_ls;

    always_comb begin
        pick_ls = ls_req;
        if (ls_req && if_req) begin
            pick_ls = !last_ls;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_ls <= 1'b0;
        end else if (start) begin
            last_ls <= pick_ls;
        end
    end
`else
    // Fixed priority: load/store wins whenever it is requesting.
    always_comb begin
        pick_ls = ls_req;
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any_req ? ACCESS : IDLE;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner_ls  <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
            lat_we    <= 1'b0;
        end else begin
            state <= state_next;
            // Inputs are only captured here; later changes cannot disturb the
            // transaction in flight.
            if (start) begin
                owner_ls  <= pick_ls;
                lat_addr  <= pick_ls ? ls_addr : if_addr;
                lat_wdata <= pick_ls ? ls_wdata : 16'h0000;
                lat_we    <= pick_ls & ls_we;
            end
        end
    end

    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_valid  = 1'b0;
        ls_valid  = 1'b0;
        rdata     = 16'h0000;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        case (state)
            ACCESS: begin
                if_gnt    = !owner_ls;
                ls_gnt    = owner_ls;
                mem_en    = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
            end
            RESP: begin
                if_gnt   = !owner_ls;
                ls_gnt   = owner_ls;
                if_valid = !owner_ls;
                ls_valid = owner_ls;
                rdata    = lat_we ? 16'h0000 : mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
